forward_control: RTL and testbench



---
 rtl/forward_control_pkg.sv | 17 +
 rtl/forward_select.sv | 40 ++++
 rtl/forward_control.sv | 130 +++++++++++++
 tb/tb_forward_control.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/forward_control_pkg.sv
// Forwarding select encodings shared with the EX operand multiplexers.
// Optional perf counters in forward_control: FORWARD_PERF_COUNT_EN.
package forward_control_pkg;

    localparam int FWD_CODE_W = 2;

    typedef enum logic [FWD_CODE_W-1:0] {
        NO_FORWARD    = 2'b00,
        EXMEM_FORWARD = 2'b01,
        MEMWB_FORWARD = 2'b10
    } fwd_code_e;

    function automatic logic fwd_used(input logic [FWD_CODE_W-1:0] code);
        return code != NO_FORWARD;
    endfunction

endpackage

// File: rtl/forward_select.sv
// Compares one source register against the EX/MEM destination shadow.
// Returns the forward select and whether the EX producer is a pending load.
module forward_select
    import forward_control_pkg::*;
#(
    parameter int REG_NUM_WIDTH = 5
) (
    input  logic [REG_NUM_WIDTH-1:0] src,
    input  logic                     ex_valid,
    input  logic                     ex_we,
    input  logic                     ex_load,
    input  logic [REG_NUM_WIDTH-1:0] ex_dst,
    input  logic                     mem_valid,
    input  logic                     mem_we,
    input  logic [REG_NUM_WIDTH-1:0] mem_dst,
    output logic [FWD_CODE_W-1:0]    code,
    output logic                     load_hazard
);

    logic live_src;
    logic ex_hit;
    logic mem_hit;

    // r0 is hard-wired zero, so it never creates a dependency
    assign live_src = src != '0;
    assign ex_hit   = ex_valid & ex_we & (ex_dst == src) & live_src;
    assign mem_hit  = mem_valid & mem_we & (mem_dst == src) & live_src;

    assign load_hazard = ex_hit & ex_load;

    always_comb begin
        code = NO_FORWARD;
        if (ex_hit & !ex_load) begin
            code = EXMEM_FORWARD;
        end else if (mem_hit) begin
            code = MEMWB_FORWARD;
        end
    end

endmodule

// File: rtl/forward_control.sv
// Registered forwarding selects and load-use stall beside the ID/EX register.
// Define FORWARD_PERF_COUNT_EN to build the stall/forward counters.
module forward_control
    import forward_control_pkg::*;
#(
    parameter int REG_NUM_WIDTH = 5,
    parameter int COUNT_WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     idValid,
    input  logic [REG_NUM_WIDTH-1:0] idSrcA,
    input  logic [REG_NUM_WIDTH-1:0] idSrcB,
    input  logic [REG_NUM_WIDTH-1:0] idDst,
    input  logic                     idWrEnable,
    input  logic                     idIsLoad,
    input  logic                     memBusy,
    input  logic                     flush,
    output logic [FWD_CODE_W-1:0]    forwardCodeA,
    output logic [FWD_CODE_W-1:0]    forwardCodeB,
    output logic                     stall,
    output logic [COUNT_WIDTH-1:0]   stallCount,
    output logic [COUNT_WIDTH-1:0]   forwardCount
);

    logic                     ex_valid;
    logic                     ex_we;
    logic                     ex_load;
    logic [REG_NUM_WIDTH-1:0] ex_dst;
    logic                     mem_valid;
    logic                     mem_we;
    logic [REG_NUM_WIDTH-1:0] mem_dst;

    logic [FWD_CODE_W-1:0] next_a;
    logic [FWD_CODE_W-1:0] next_b;
    logic                  haz_a;
    logic                  haz_b;
    logic                  advance;
    logic                  load_id;

    forward_select #(.REG_NUM_WIDTH(REG_NUM_WIDTH)) u_sel_a (
        .src        (idSrcA),
        .ex_valid   (ex_valid),
        .ex_we      (ex_we),
        .ex_load    (ex_load),
        .ex_dst     (ex_dst),
        .mem_valid  (mem_valid),
        .mem_we     (mem_we),
        .mem_dst    (mem_dst),
        .code       (next_a),
        .load_hazard(haz_a)
    );

    forward_select #(.REG_NUM_WIDTH(REG_NUM_WIDTH)) u_sel_b (
        .src        (idSrcB),
        .ex_valid   (ex_valid),
        .ex_we      (ex_we),
        .ex_load    (ex_load),
        .ex_dst     (ex_dst),
        .mem_valid  (mem_valid),
        .mem_we     (mem_we),
        .mem_dst    (mem_dst),
        .code       (next_b),
        .load_hazard(haz_b)
    );

    assign stall = idValid & (haz_a | haz_b) & !flush;

    // flush overrides a memory freeze; otherwise memBusy holds everything
    assign advance = flush | !memBusy;
    assign load_id = !flush & idValid & !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_we        <= 1'b0;
            ex_load      <= 1'b0;
            ex_dst       <= '0;
            mem_valid    <= 1'b0;
            mem_we       <= 1'b0;
            mem_dst      <= '0;
            forwardCodeA <= NO_FORWARD;
            forwardCodeB <= NO_FORWARD;
        end else if (advance) begin
            mem_valid <= ex_valid;
            mem_we    <= ex_we;
            mem_dst   <= ex_dst;
            if (load_id) begin
                ex_valid     <= 1'b1;
                ex_we        <= idWrEnable;
                ex_load      <= idIsLoad;
                ex_dst       <= idDst;
                forwardCodeA <= next_a;
                forwardCodeB <= next_b;
            end else begin
                ex_valid     <= 1'b0;
                ex_we        <= 1'b0;
                ex_load      <= 1'b0;
                ex_dst       <= '0;
                forwardCodeA <= NO_FORWARD;
                forwardCodeB <= NO_FORWARD;
            end
        end
    end

`ifdef FORWARD_PERF_COUNT_EN
    logic [COUNT_WIDTH-1:0] fwd_inc;

    assign fwd_inc = COUNT_WIDTH'(fwd_used(next_a))
                   + COUNT_WIDTH'(fwd_used(next_b));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCount   <= '0;
            forwardCount <= '0;
        end else if (advance) begin
            if (stall) begin
                stallCount <= stallCount + 1'b1;
            end
            if (load_id) begin
                forwardCount <= forwardCount + fwd_inc;
            end
        end
    end
`else
    assign stallCount   = '0;
    assign forwardCount = '0;
`endif

endmodule

// File: tb/tb_forward_control.sv
// Directed bench for forward_control: forwarding, load-use, r0, flush,
// memBusy freeze and asynchronous reset.
module tb_forward_control;
    import forward_control_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        idValid;
    logic [4:0]  idSrcA;
    logic [4:0]  idSrcB;
    logic [4:0]  idDst;
    logic        idWrEnable;
    logic        idIsLoad;
    logic        memBusy;
    logic        flush;
    logic [1:0]  forwardCodeA;
    logic [1:0]  forwardCodeB;
    logic        stall;
    logic [31:0] stallCount;
    logic [31:0] forwardCount;

    int n_checks = 0;
    int n_pass   = 0;

    forward_control #(.REG_NUM_WIDTH(5), .COUNT_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .idValid     (idValid),
        .idSrcA      (idSrcA),
        .idSrcB      (idSrcB),
        .idDst       (idDst),
        .idWrEnable  (idWrEnable),
        .idIsLoad    (idIsLoad),
        .memBusy     (memBusy),
        .flush       (flush),
        .forwardCodeA(forwardCodeA),
        .forwardCodeB(forwardCodeB),
        .stall       (stall),
        .stallCount  (stallCount),
        .forwardCount(forwardCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic issue(input logic v, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d,
                         input logic we, input logic ld);
        idValid    = v;
        idSrcA     = a;
        idSrcB     = b;
        idDst      = d;
        idWrEnable = we;
        idIsLoad   = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt(input int n);
`ifdef FORWARD_PERF_COUNT_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    initial begin
        rst     = 1'b1;
        memBusy = 1'b0;
        flush   = 1'b0;
        issue(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_codeA", 32'(forwardCodeA), 32'(NO_FORWARD));
        check("rst_codeB", 32'(forwardCodeB), 32'(NO_FORWARD));
        check("rst_stall", 32'(stall), 0);
        check("rst_scnt", stallCount, 0);
        check("rst_fcnt", forwardCount, 0);
        @(negedge clk);
        rst = 1'b0;

        // back-to-back ALU ops on r3
        issue(1, 0, 0, 3, 1, 0);
        tick();
        issue(1, 3, 4, 6, 1, 0);
        #1 check("b2b_stall", 32'(stall), 0);
        tick();
        check("b2b_codeA", 32'(forwardCodeA), 32'(EXMEM_FORWARD));
        check("b2b_codeB", 32'(forwardCodeB), 32'(NO_FORWARD));
        check("b2b_fcnt", forwardCount, cnt(1));

        // one independent instruction between r5 producer and consumer
        issue(1, 0, 0, 5, 1, 0);
        tick();
        issue(1, 1, 2, 8, 1, 0);
        tick();
        check("ind_codeA", 32'(forwardCodeA), 32'(NO_FORWARD));
        check("ind_codeB", 32'(forwardCodeB), 32'(NO_FORWARD));
        issue(1, 9, 5, 10, 1, 0);
        tick();
        check("mem_codeA", 32'(forwardCodeA), 32'(NO_FORWARD));
        check("mem_codeB", 32'(forwardCodeB), 32'(MEMWB_FORWARD));

        // load r7 then use as srcA
        issue(1, 0, 0, 7, 1, 1);
        tick();
        issue(1, 7, 0, 11, 1, 0);
        #1 check("lu_stall", 32'(stall), 1);
        tick();
        check("lu_bub_codeA", 32'(forwardCodeA), 32'(NO_FORWARD));
        check("lu_bub_codeB", 32'(forwardCodeB), 32'(NO_FORWARD));
        check("lu_stall_off", 32'(stall), 0);
        tick();
        check("lu_codeA", 32'(forwardCodeA), 32'(MEMWB_FORWARD));
        check("lu_scnt", stallCount, cnt(1));
        check("lu_fcnt", forwardCount, cnt(3));

        // r0 never forwards
        issue(1, 0, 0, 0, 1, 0);
        tick();
        issue(1, 0, 0, 0, 1, 0);
        tick();
        issue(1, 0, 0, 12, 1, 0);
        #1 check("r0_stall", 32'(stall), 0);
        tick();
        check("r0_codeA", 32'(forwardCodeA), 32'(NO_FORWARD));
        check("r0_codeB", 32'(forwardCodeB), 32'(NO_FORWARD));

        // flush kills a load-use stall
        issue(1, 0, 0, 2, 1, 1);
        tick();
        issue(1, 2, 2, 15, 1, 0);
        flush = 1'b1;
        #1 check("fl_stall", 32'(stall), 0);
        tick();
        flush = 1'b0;
        check("fl_codeA", 32'(forwardCodeA), 32'(NO_FORWARD));
        check("fl_codeB", 32'(forwardCodeB), 32'(NO_FORWARD));
        #1 check("fl_ex_empty", 32'(stall), 0);
        tick();
        check("same_codeA", 32'(forwardCodeA), 32'(MEMWB_FORWARD));
        check("same_codeB", 32'(forwardCodeB), 32'(MEMWB_FORWARD));
        check("fl_scnt", stallCount, cnt(1));

        // memBusy freeze during an EX-forward
        issue(1, 0, 0, 13, 1, 0);
        tick();
        issue(1, 13, 1, 14, 1, 0);
        memBusy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frz_codeA", 32'(forwardCodeA), 32'(NO_FORWARD));
        end
        check("frz_fcnt", forwardCount, cnt(5));
        memBusy = 1'b0;
        tick();
        check("rel_codeA", 32'(forwardCodeA), 32'(EXMEM_FORWARD));
        check("rel_codeB", 32'(forwardCodeB), 32'(NO_FORWARD));
        issue(0, 0, 0, 0, 0, 0);
        tick();
        check("once_codeA", 32'(forwardCodeA), 32'(NO_FORWARD));
        check("rel_fcnt", forwardCount, cnt(6));

        // asynchronous reset mid-sequence
        issue(1, 0, 0, 20, 1, 0);
        tick();
        issue(1, 20, 20, 21, 1, 0);
        tick();
        check("pre_codeA", 32'(forwardCodeA), 32'(EXMEM_FORWARD));
        #2 rst = 1'b1;
        #1;
        check("arst_codeA", 32'(forwardCodeA), 32'(NO_FORWARD));
        check("arst_codeB", 32'(forwardCodeB), 32'(NO_FORWARD));
        check("arst_fcnt", forwardCount, 0);
        #1 rst = 1'b0;
        issue(1, 20, 20, 22, 1, 0);
        tick();
        check("post_codeA", 32'(forwardCodeA), 32'(NO_FORWARD));
        check("post_codeB", 32'(forwardCodeB), 32'(NO_FORWARD));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
